// File: rtl/mult_div_pkg.sv
// Shared definitions for the multicycle multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mult_div_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DZ   = 2'd3
    } state_t;

endpackage

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division iteration on unsigned magnitudes.
// Latency: combinational.
// Backpressure: none.
// Ports: rem_in (partial remainder, always < divisor), dividend_bit (next
// dividend bit shifted in), divisor; rem_out (new remainder), q_bit.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    // trial < 2*divisor, so after a successful subtract the result fits in
    // WIDTH bits again; the extra bit only matters for the compare.
    always_comb begin
        trial   = {rem_in, dividend_bit};
        diff    = trial - {1'b0, divisor};
        q_bit   = (trial >= {1'b0, divisor});
        rem_out = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed/unsigned multiply and divide producing the HI/LO pair.
// Latency: WIDTH+1 edges from the accepting edge; 1 edge for divide-by-zero
//   (and for any divide when MULT_DIV_UNIT_DIV_EN is undefined).
// Backpressure: start and wr_hi/wr_lo are ignored while busy.
// Ports: clk, rst (sync, active high); start/op/a/b request; wr_hi/wr_lo/
// wr_data direct HI/LO writes; busy, done, div_zero status; hi, lo results.
// Build option: define MULT_DIV_UNIT_DIV_EN to include the divide datapath.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t             state, state_nxt;
    logic [2*WIDTH-1:0] acc;        // mult: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   opnd_b;     // multiplicand or divisor magnitude
    logic [CW-1:0]      cnt;
    logic               neg_lo;     // product sign, or quotient sign for divides

    logic               is_signed, is_div, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               load, step, fin, idle_wr, done_set, dz_set;
    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] acc_step, prod_fix;
    logic [WIDTH-1:0]   res_hi, res_lo;

`ifdef MULT_DIV_UNIT_DIV_EN
    logic               op_div;
    logic               neg_hi;     // remainder follows the dividend sign
    logic [WIDTH-1:0]   div_rem;
    logic               div_q;

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in       (acc[2*WIDTH-1:WIDTH]),
        .dividend_bit (acc[WIDTH-1]),
        .divisor      (opnd_b),
        .rem_out      (div_rem),
        .q_bit        (div_q)
    );
`endif

    // Operand decode; the most-negative value maps to its unsigned magnitude.
    always_comb begin
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        is_div    = (op == OP_DIV) || (op == OP_DIVU);
        a_neg     = is_signed && a[WIDTH-1];
        b_neg     = is_signed && b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef MULT_DIV_UNIT_DIV_EN
                    state_nxt = (is_div && (b == '0)) ? DZ : RUN;
`else
                    state_nxt = is_div ? DZ : RUN;
`endif
                end
            end
            RUN:     if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            DZ:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs and datapath controls
    always_comb begin
        busy     = (state != IDLE);
        load     = (state == IDLE) && start;
        step     = (state == RUN);
        fin      = (state == FIX);
        idle_wr  = (state == IDLE);
        done_set = (state == FIX) || (state == DZ);
`ifdef MULT_DIV_UNIT_DIV_EN
        dz_set   = (state == DZ);
`else
        dz_set   = 1'b0;
`endif
    end

    // One iteration: shift-add for multiply, restoring step for divide.
    always_comb begin
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_b} : {(WIDTH+1){1'b0}});
        acc_step = {add_sum, acc[WIDTH-1:1]};
`ifdef MULT_DIV_UNIT_DIV_EN
        if (op_div) acc_step = {div_rem, acc[WIDTH-2:0], div_q};
`endif
    end

    // Sign correction applied in FIX.
    always_comb begin
        prod_fix = neg_lo ? -acc : acc;
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
`ifdef MULT_DIV_UNIT_DIV_EN
        if (op_div) begin
            res_lo = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            res_hi = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end
`endif
    end

    // Architected state: HI/LO and the completion pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= done_set;
            div_zero <= dz_set;
            if (idle_wr && wr_hi) hi <= wr_data;
            if (idle_wr && wr_lo) lo <= wr_data;
            if (fin) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end

    // Working registers; only meaningful between load and FIX.
    always_ff @(posedge clk) begin
        if (load) begin
            acc    <= {{WIDTH{1'b0}}, a_mag};
            opnd_b <= b_mag;
            cnt    <= '0;
            neg_lo <= a_neg ^ b_neg;
`ifdef MULT_DIV_UNIT_DIV_EN
            neg_hi <= a_neg;
            op_div <= is_div;
`endif
        end else if (step) begin
            acc <= acc_step;
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Parametrised multicycle multiply/divide unit for the multicycle CPU datapath. It produces the HI/LO register pair consumed by the mem-to-reg path. It runs signed and unsigned multiply and divide over WIDTH-bit operands taken from the A/B registers. The control unit drives it through a start/done handshake and may write HI or LO directly (move-to-HI/LO).

## Interface
- WIDTH, 32, operand and HI/LO width; minimum 4.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- a  in  WIDTH  multiplicand or dividend; sampled with start.
- b  in  WIDTH  multiplier or divisor; sampled with start.
- wr_hi  in  1  direct write of HI from wr_data; IDLE only.
- wr_lo  in  1  direct write of LO from wr_data; IDLE only.
- wr_data  in  WIDTH  direct-write data.
- busy  out  1  high from the edge after start is accepted until the done cycle.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  one-cycle pulse, coincident with done, when a divide had b == 0.
- hi  out  WIDTH  multiply upper half, or divide remainder.
- lo  out  WIDTH  multiply lower half, or divide quotient.

## Operation
- States and transitions:
  - IDLE: start is accepted here. b == 0 on a divide goes to DZ; every other start goes to RUN.
  - RUN: WIDTH iterations, counted by a counter of clog2(WIDTH)+1 bits; then goes to FIX.
  - FIX: sign correction, HI/LO write, done; then back to IDLE.
  - DZ: pulses div_zero and done; then back to IDLE.
- Operand capture: for signed ops, operands are latched as magnitudes and the result signs are latched.
  - Product sign = sign(a) XOR sign(b).
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- Multiply: radix-2 shift-add over a 2*WIDTH-bit accumulator. In FIX, the result is two's-complement negated if the product sign is set, then hi = upper half, lo = lower half.
- Divide: restoring division, one quotient bit per RUN cycle. Quotient truncates toward zero; remainder takes the sign of the dividend.
- Signed overflow: most-negative / -1 gives lo = most-negative, hi = 0. No flag is raised.
- Divide by zero: no iteration, hi/lo unchanged, div_zero = 1.
- While busy: start and wr_hi/wr_lo are ignored.
- Simultaneous events in IDLE:
  - wr_hi/wr_lo and start in the same cycle: the write takes effect and start is also accepted; the later result overwrites HI/LO.
  - wr_hi and wr_lo together: both registers are written.
- hi and lo hold their value between writes.

## Timing
- Reset values: hi = 0, lo = 0, busy = 0, done = 0, div_zero = 0, state = IDLE.
- Start-accepting edge is E0.
- Normal op:
  - busy = 1 after E0.
  - RUN occupies E1..E(WIDTH).
  - FIX is at E(WIDTH+1): hi/lo update and done = 1 for the following cycle; busy drops at the same time.
  - Latency is WIDTH+1 edges (33 for WIDTH = 32).
- Divide by zero: done and div_zero are high for the cycle after E1. Latency is 1 edge.
- done and start in the same cycle: start is accepted (state is IDLE), giving back-to-back operation.
- rst asserted mid-operation: the next edge returns to IDLE, clears hi/lo, and produces no done pulse.

## Configuration
- MULT_DIV_UNIT_DIV_EN defined: divide datapath, DZ state and div_zero logic are compiled in.
- MULT_DIV_UNIT_DIV_EN undefined:
  - op 10/11 go to a one-cycle completion: done pulses after E1.
  - hi/lo are unchanged and div_zero stays 0.
  - No divide hardware is present.

## Structure
- Package mult_div_pkg holds:
  - op encoding constants: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - the state enum: IDLE, RUN, FIX, DZ.
- One sub-module, div_step: combinational single restoring-division iteration.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new remainder and quotient bit.
  - Instantiated only under MULT_DIV_UNIT_DIV_EN.

## Test plan
Unless stated otherwise, WIDTH = 32 and MULT_DIV_UNIT_DIV_EN is defined.
1. MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; done exactly 33 edges after E0; busy high throughout.
2. MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. A second start applied in the done cycle is accepted: 5*6 gives hi=0, lo=30.
3. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
4. DIVU a=100, b=0 with hi=0x11, lo=0x22 preloaded via wr_hi/wr_lo -> done and div_zero for one cycle after E1; hi/lo stay 0x11/0x22.
5. Start MULT 3*4, then:
   - pulse start and wr_lo at E5 -> both ignored;
   - assert rst at E10 -> after the next edge, hi=lo=0, busy=0, and no done ever appears.
6. Build with MULT_DIV_UNIT_DIV_EN undefined, issue DIV 9/3 -> done after E1, div_zero=0, hi/lo unchanged.
